// File: rtl/memory_core.sv
// memory_core: tile memory core with a 1024 x 16 SRAM used as a fixed-depth line buffer.
//
// Ports
//   clk_in          single clock, all state updates on the rising edge
//   reset           synchronous active-high reset (config, pointers, outputs; SRAM kept)
//   clk_en          line-buffer clock enable; 0 freezes pointer/count state
//   config_en       writes the tile config register when config_addr[7:0] == 0
//   config_en_sram  bank select for configuration SRAM access (lowest set bit wins)
//   config_read     configuration SRAM read strobe (result on data_out next cycle)
//   config_write    configuration SRAM write strobe
//   config_addr     [7:0] register select, [31:24] SRAM word address within the bank
//   config_data     configuration write data
//   data_in         stream input word
//   wen_in          stream push
//   ren_in          unused in line-buffer mode
//   chain_in        reserved, ignored
//   flush           synchronous clear of write pointer, fill count and valid
//   data_out        registered output word
//   valid_out       data_out qualifier for line-buffer output
//
// Config register: [1:0] mode (0 = line buffer), [2] tile_en, [15:3] depth.
module memory_core (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        config_en,
    input  logic [3:0]  config_en_sram,
    input  logic        config_read,
    input  logic        config_write,
    input  logic [31:0] config_addr,
    input  logic [31:0] config_data,
    input  logic [15:0] data_in,
    input  logic        wen_in,
    input  logic        ren_in,
    input  logic        chain_in,
    input  logic        flush,
    output logic [15:0] data_out,
    output logic        valid_out
);

    logic [31:0] cfg_q;
    logic [1:0]  mode;
    logic        tile_en;
    logic [12:0] depth;
    logic [10:0] eff_depth;

    logic [9:0]  wr_ptr_q, wr_ptr_d;
    logic [10:0] count_q, count_d;
    logic [15:0] data_q;
    logic        valid_q;

    logic [15:0] mem [1024];

    logic [1:0]  bank;
    logic [9:0]  sram_addr;
    logic        sram_sel;
    logic        cfg_rd;
    logic        cfg_wr;
    logic        cfg_access;
    logic        lb_active;
    logic        push;
    logic        pop;

    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic [9:0]  mem_raddr;

    logic        unused_bits;

    assign mode    = cfg_q[1:0];
    assign tile_en = cfg_q[2];
    assign depth   = cfg_q[15:3];

    // Storage holds 1024 words, so deeper settings behave as a full-memory delay.
    assign eff_depth = (depth > 13'd1024) ? 11'd1024 : depth[10:0];

    // Lowest set bank-select bit wins.
    always_comb begin
        bank = 2'd3;
        if (config_en_sram[0]) begin
            bank = 2'd0;
        end else if (config_en_sram[1]) begin
            bank = 2'd1;
        end else if (config_en_sram[2]) begin
            bank = 2'd2;
        end
    end

    assign sram_sel   = |config_en_sram;
    assign sram_addr  = {bank, config_addr[31:24]};
    assign cfg_rd     = sram_sel && config_read;
    assign cfg_wr     = sram_sel && config_write;
    assign cfg_access = cfg_rd || cfg_wr;

    // Configuration SRAM access owns the memory port, so a coincident push is dropped.
    assign lb_active = tile_en && (mode == 2'd0) && clk_en;
    assign push      = lb_active && wen_in && !flush && !cfg_access;
    assign pop       = push && (eff_depth != 11'd0) && (count_q >= eff_depth);

    assign mem_we    = (cfg_wr || push) && !reset;
    assign mem_waddr = cfg_wr ? sram_addr : wr_ptr_q;
    assign mem_wdata = cfg_wr ? config_data[15:0] : data_in;
    // For depth 1024 the read address equals the write address; the read returns the
    // old word, which is exactly the one pushed 1024 pushes earlier.
    assign mem_raddr = cfg_rd ? sram_addr : (wr_ptr_q - eff_depth[9:0]);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (push) begin
            wr_ptr_d = wr_ptr_q + 10'd1;
            count_d  = (count_q >= eff_depth) ? eff_depth : (count_q + 11'd1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cfg_q <= '0;
        end else if (config_en && (config_addr[7:0] == 8'h00)) begin
            cfg_q <= config_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= pop;
        end
    end

    // SRAM array with the registered output word; the array itself is never reset.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (reset) begin
            data_q <= '0;
        end else if (cfg_rd || pop) begin
            data_q <= mem[mem_raddr];
        end else if (mode != 2'd0) begin
            data_q <= '0;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

    assign unused_bits = ^{ren_in, chain_in, config_addr[23:8], cfg_q[31:16]};

endmodule

// File: tb/tb_memory_core.sv
// tb_memory_core: directed and randomized checks of memory_core against a queue-based
// model of the line buffer (output = word pushed D pushes earlier) plus an array model
// of the configuration-visible SRAM.
module tb_memory_core;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        config_en;
    logic [3:0]  config_en_sram;
    logic        config_read;
    logic        config_write;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic [15:0] data_in;
    logic        wen_in;
    logic        ren_in;
    logic        chain_in;
    logic        flush;
    logic [15:0] data_out;
    logic        valid_out;

    always #5 clk_in = ~clk_in;

    memory_core dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .clk_en         (clk_en),
        .config_en      (config_en),
        .config_en_sram (config_en_sram),
        .config_read    (config_read),
        .config_write   (config_write),
        .config_addr    (config_addr),
        .config_data    (config_data),
        .data_in        (data_in),
        .wen_in         (wen_in),
        .ren_in         (ren_in),
        .chain_in       (chain_in),
        .flush          (flush),
        .data_out       (data_out),
        .valid_out      (valid_out)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_cfg = '0;
    logic [15:0] m_hist[$];
    logic [15:0] m_smem [1024];
    int          m_wcnt = 0;
    logic [15:0] m_data = '0;
    logic        m_valid = 1'b0;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Predict the effect of the currently driven inputs, clock once, compare outputs.
    task automatic cycle(input string tag);
        int          d;
        int          bank;
        int          a;
        logic        sel;
        logic        access;
        logic        rd;
        logic        push;
        logic [15:0] nd;
        logic        nv;
        sel  = |config_en_sram;
        bank = config_en_sram[0] ? 0 : config_en_sram[1] ? 1 : config_en_sram[2] ? 2 : 3;
        a    = bank * 256 + int'(config_addr[31:24]);
        d    = (int'(m_cfg[15:3]) > 1024) ? 1024 : int'(m_cfg[15:3]);
        if (reset) begin
            m_cfg = '0;
            m_hist.delete();
            m_wcnt = 0;
            m_data = '0;
            m_valid = 1'b0;
        end else begin
            access = sel && (config_read || config_write);
            rd     = sel && config_read;
            push   = m_cfg[2] && (m_cfg[1:0] == 2'd0) && clk_en && wen_in && !flush && !access;
            nd = m_data;
            nv = 1'b0;
            if (rd) nd = m_smem[a];
            else if (m_cfg[1:0] != 2'd0) nd = '0;
            if (push) begin
                if (d > 0 && m_hist.size() >= d) begin
                    nd = m_hist[m_hist.size() - d];
                    nv = 1'b1;
                end
                m_hist.push_back(data_in);
                if (m_hist.size() > 1100) void'(m_hist.pop_front());
                m_smem[m_wcnt] = data_in;
                m_wcnt = (m_wcnt + 1) % 1024;
            end
            if (sel && config_write) m_smem[a] = config_data[15:0];
            if (flush) begin
                m_hist.delete();
                m_wcnt = 0;
            end
            if (config_en && config_addr[7:0] == 8'h00) m_cfg = config_data;
            m_data  = nd;
            m_valid = nv;
        end
        @(posedge clk_in);
        #1;
        check16({tag, "_data"}, data_out, m_data);
        check16({tag, "_valid"}, {15'd0, valid_out}, {15'd0, m_valid});
    endtask

    task automatic push_word(input logic [15:0] v, input string tag);
        wen_in  = 1'b1;
        data_in = v;
        cycle(tag);
        wen_in  = 1'b0;
    endtask

    task automatic write_cfg(input logic [31:0] v);
        config_en   = 1'b1;
        config_addr = '0;
        config_data = v;
        cycle("cfg");
        config_en   = 1'b0;
    endtask

    task automatic sram_access(input logic [3:0] sel, input logic [7:0] word,
                               input logic wr, input logic [15:0] v, input string tag);
        config_en_sram = sel;
        config_addr    = {word, 24'd0};
        config_data    = {16'd0, v};
        config_write   = wr;
        config_read    = !wr;
        cycle(tag);
        config_en_sram = '0;
        config_write   = 1'b0;
        config_read    = 1'b0;
        config_addr    = '0;
    endtask

    initial begin
        int          vcount;
        logic [15:0] first;

        reset = 1'b1; clk_en = 1'b1; config_en = 1'b0; config_en_sram = '0;
        config_read = 1'b0; config_write = 1'b0; config_addr = '0; config_data = '0;
        data_in = '0; wen_in = 1'b0; ren_in = 1'b0; chain_in = 1'b0; flush = 1'b0;

        cycle("reset");
        cycle("reset");
        check16("reset_data_out", data_out, 16'h0000);
        reset = 1'b0;

        // Configuration SRAM write/read, write ignores clk_en
        clk_en = 1'b0;
        sram_access(4'b0001, 8'd7, 1'b1, 16'hBEEF, "sram_wr");
        clk_en = 1'b1;
        sram_access(4'b0001, 8'd7, 1'b0, 16'h0000, "sram_rd");
        check16("sram_rd_beef", data_out, 16'hBEEF);
        check16("sram_rd_valid", {15'd0, valid_out}, 16'd0);

        // Multi-bit bank select resolves to the lowest set bit
        sram_access(4'b0100, 8'd9, 1'b1, 16'hA5A5, "bank2_wr");
        sram_access(4'b1000, 8'd9, 1'b1, 16'h5A5A, "bank3_wr");
        sram_access(4'b1100, 8'd9, 1'b0, 16'h0000, "bank_low_rd");
        check16("bank_lowest_bit", data_out, 16'hA5A5);
        sram_access(4'b1000, 8'd9, 1'b0, 16'h0000, "bank3_rd");
        check16("bank3_value", data_out, 16'h5A5A);

        // Config write at a non-zero register address is ignored; tile stays disabled
        config_en = 1'b1; config_addr = 32'h0000_0001; config_data = 32'h7C;
        cycle("cfg_badaddr");
        config_en = 1'b0; config_addr = '0;
        for (int i = 0; i < 20; i++) push_word(16'(500 + i), "disabled_push");
        check16("disabled_valid", {15'd0, valid_out}, 16'd0);

        // Depth 15 stream: 15 silent pushes, then the first word
        write_cfg(32'h0000_007C);
        vcount = 0;
        for (int i = 1; i <= 15; i++) begin
            push_word(16'(i), "fill");
            vcount += int'(valid_out);
        end
        check16("fill_no_valid", 16'(vcount), 16'd0);
        push_word(16'd16, "first_out");
        check16("first_out_data", data_out, 16'd1);
        check16("first_out_valid", {15'd0, valid_out}, 16'd1);
        for (int i = 17; i <= 40; i++) push_word(16'(i), "stream");

        // Flush after idle cycles; a push in the flush cycle is discarded
        for (int i = 0; i < 3; i++) cycle("idle");
        flush = 1'b1; wen_in = 1'b1; data_in = 16'd999;
        cycle("flush");
        flush = 1'b0; wen_in = 1'b0;
        check16("flush_valid", {15'd0, valid_out}, 16'd0);
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            push_word(16'(100 + i), "refill");
            vcount += int'(valid_out);
        end
        check16("refill_no_valid", 16'(vcount), 16'd0);
        push_word(16'd115, "post_flush_first");
        check16("post_flush_first", data_out, 16'd100);

        // Random push pattern
        for (int i = 0; i < 200; i++) begin
            wen_in  = 1'($urandom_range(0, 1));
            data_in = 16'($urandom);
            cycle("random");
        end
        wen_in = 1'b0;

        // clk_en low with pushes requested
        for (int i = 0; i < 10; i++) push_word(16'(300 + i), "pre_stall");
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) push_word(16'hDEAD, "stall");
        check16("stall_valid", {15'd0, valid_out}, 16'd0);
        clk_en = 1'b1;
        for (int i = 0; i < 20; i++) push_word(16'(400 + i), "post_stall");

        // Configuration SRAM write wins over a push in the same cycle
        wen_in = 1'b1; data_in = 16'h4444;
        sram_access(4'b0010, 8'd3, 1'b1, 16'h3333, "prio_wr");
        wen_in = 1'b0;
        for (int i = 0; i < 5; i++) push_word(16'(600 + i), "prio_after");
        sram_access(4'b0010, 8'd3, 1'b0, 16'h0000, "prio_rd");

        // Reserved mode: outputs forced low, line-buffer state held
        write_cfg(32'h0000_007D);
        for (int i = 0; i < 5; i++) push_word(16'(700 + i), "mode1");
        check16("mode1_data", data_out, 16'h0000);
        write_cfg(32'h0000_007C);
        for (int i = 0; i < 20; i++) push_word(16'(800 + i), "mode0_resume");

        // Depth 0 never produces output
        write_cfg(32'h0000_0004);
        flush = 1'b1; cycle("flush_d0"); flush = 1'b0;
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            push_word(16'($urandom), "depth0");
            vcount += int'(valid_out);
        end
        check16("depth0_no_valid", 16'(vcount), 16'd0);

        // Depth above capacity clamps to 1024 words
        write_cfg((32'd2000 << 3) | 32'h4);
        flush = 1'b1; cycle("flush_big"); flush = 1'b0;
        first = 16'($urandom);
        push_word(first, "big_first");
        for (int i = 1; i < 1024; i++) push_word(16'($urandom), "big_fill");
        check16("big_fill_valid", {15'd0, valid_out}, 16'd0);
        push_word(16'($urandom), "big_wrap");
        check16("big_wrap_data", data_out, first);
        for (int i = 0; i < 60; i++) push_word(16'($urandom), "big_stream");

        // Reset mid-stream overrides flush, config and SRAM writes, and pushes
        write_cfg(32'h0000_007C);
        flush = 1'b1; cycle("flush_rst"); flush = 1'b0;
        for (int i = 0; i < 20; i++) push_word(16'(900 + i), "pre_reset");
        sram_access(4'b0010, 8'd20, 1'b1, 16'h1234, "keep_wr");
        reset = 1'b1; wen_in = 1'b1; data_in = 16'h7777; flush = 1'b1;
        config_en = 1'b1; config_addr = '0; config_data = 32'h7C;
        config_en_sram = 4'b0010; config_write = 1'b1; config_addr[31:24] = 8'd20;
        config_data[15:0] = 16'h5555;
        cycle("reset_mid");
        reset = 1'b0; wen_in = 1'b0; flush = 1'b0; config_en = 1'b0;
        config_en_sram = '0; config_write = 1'b0; config_addr = '0; config_data = '0;
        check16("reset_mid_data", data_out, 16'h0000);
        check16("reset_mid_valid", {15'd0, valid_out}, 16'd0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            push_word(16'(950 + i), "after_reset");
            vcount += int'(valid_out);
        end
        check16("after_reset_no_valid", 16'(vcount), 16'd0);
        sram_access(4'b0010, 8'd20, 1'b0, 16'h0000, "keep_rd");
        check16("reset_blocks_sram_wr", data_out, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
